// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RV32I pipeline.
// Drives the data-memory req/ack handshake and stalls upstream while memory is slow.
// Builds byte enables and lane-replicated store data, and aligns and extends load data.
// Drives the MEM/WB register and the MEM-stage forwarding value.
module mem_access_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ALU_co_pype,
    input  logic [31:0] read_data2_pype2,
    input  logic [4:0]  WReg_pype2,
    input  logic [2:0]  writeback_control_pype2,
    input  logic [1:0]  MemRW_pype2,
    input  logic [1:0]  dsize_pype2,
    input  logic [2:0]  funct3_pype2,
    input  logic [31:0] PCp4_pype2,
    input  logic        is_csr_pype2,
    input  logic [11:0] csr_pype2,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        misaligned_exc,
    output logic [31:0] ALU_co_pype3,
    output logic [31:0] load_data_pype3,
    output logic [31:0] PCp4_pype3,
    output logic [4:0]  WReg_pype3,
    output logic [2:0]  writeback_control_pype3,
    output logic        is_csr_pype3,
    output logic [11:0] csr_pype3,
    output logic [31:0] fwd_mem_data
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state;

    // Copies of the access taken when entering S_WAIT, so the bus stays stable until ack
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic        we_q;
    logic        load_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;

    logic        access;
    logic        is_idle;
    logic        misaligned;
    logic        aligned_access;
    logic        misaligned_access;
    logic [1:0]  off;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic        cur_load;
    logic        cur_uns;
    logic [1:0]  cur_size;
    logic [1:0]  cur_off;
    logic [31:0] load_result;
    logic        req_int;
    logic        stall_int;
    logic        load_done;

    // Only funct3[2] (unsigned load) matters here
    logic        unused_funct3;
    assign unused_funct3 = &{1'b0, funct3_pype2[1:0]};

    // Selects the addressed lane and sign- or zero-extends it
    function automatic logic [31:0] extend_load(input logic [31:0] rd, input logic [1:0] a,
                                                input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        if (sz == 2'b00)
            return uns ? {24'b0, b} : {{24{b[7]}}, b};
        else if (sz == 2'b01)
            return uns ? {16'b0, h} : {{16{h[15]}}, h};
        else
            return rd;
    endfunction

    // Decode the incoming access: alignment check, byte enables and replicated store data
    always_comb begin
        off               = ALU_co_pype[1:0];
        access            = |MemRW_pype2;
        misaligned        = ((dsize_pype2 == 2'b01) && off[0]) ||
                            (dsize_pype2[1] && (off != 2'b00));
        aligned_access    = access && !misaligned;
        misaligned_access = access && misaligned;
        case (dsize_pype2)
            2'b00:   be_new = 4'b0001 << off;
            2'b01:   be_new = off[1] ? 4'b1100 : 4'b0011;
            default: be_new = 4'b1111;
        endcase
        case (dsize_pype2)
            2'b00:   wdata_new = {4{read_data2_pype2[7:0]}};
            2'b01:   wdata_new = {2{read_data2_pype2[15:0]}};
            default: wdata_new = read_data2_pype2;
        endcase
    end

    // Bus outputs come from the live instruction in S_IDLE and from the latched copy in S_WAIT
    always_comb begin
        is_idle      = (state == S_IDLE);
        req_int      = !rst && ((is_idle && aligned_access) || !is_idle);
        stall_int    = req_int && !dmem_ack;
        dmem_req     = req_int;
        mem_stall    = stall_int;
        dmem_we      = is_idle ? MemRW_pype2[0] : we_q;
        dmem_addr    = is_idle ? {ALU_co_pype[31:2], 2'b00} : addr_q;
        dmem_be      = is_idle ? be_new : be_q;
        dmem_wdata   = is_idle ? wdata_new : wdata_q;
        cur_load     = is_idle ? MemRW_pype2[1] : load_q;
        cur_uns      = is_idle ? funct3_pype2[2] : uns_q;
        cur_size     = is_idle ? dsize_pype2 : size_q;
        cur_off      = is_idle ? off : off_q;
        load_result  = extend_load(dmem_rdata, cur_off, cur_size, cur_uns);
        load_done    = req_int && dmem_ack && cur_load;
        fwd_mem_data = load_done ? load_result : ALU_co_pype;
    end

    // Handshake FSM: wait for ack on slow accesses, holding a copy of the request
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            off_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (aligned_access && !dmem_ack) begin
                        state   <= S_WAIT;
                        addr_q  <= {ALU_co_pype[31:2], 2'b00};
                        wdata_q <= wdata_new;
                        be_q    <= be_new;
                        we_q    <= MemRW_pype2[0];
                        load_q  <= MemRW_pype2[1];
                        uns_q   <= funct3_pype2[2];
                        size_q  <= dsize_pype2;
                        off_q   <= off;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // MEM/WB register: copy on non-stalled edges, bubble while stalled or on a misaligned access
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_exc          <= 1'b0;
            ALU_co_pype3            <= '0;
            load_data_pype3         <= '0;
            PCp4_pype3              <= '0;
            WReg_pype3              <= '0;
            writeback_control_pype3 <= '0;
            is_csr_pype3            <= 1'b0;
            csr_pype3               <= '0;
        end else begin
            misaligned_exc  <= is_idle && misaligned_access;
            ALU_co_pype3    <= ALU_co_pype;
            PCp4_pype3      <= PCp4_pype2;
            csr_pype3       <= csr_pype2;
            load_data_pype3 <= load_done ? load_result : 32'b0;
            if (stall_int || (is_idle && misaligned_access)) begin
                WReg_pype3              <= '0;
                writeback_control_pype3 <= '0;
                is_csr_pype3            <= 1'b0;
            end else begin
                WReg_pype3              <= WReg_pype2;
                writeback_control_pype3 <= writeback_control_pype2;
                is_csr_pype3            <= is_csr_pype2;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: table of single-cycle vectors plus hand-written
// sequences for wait states and reset during an outstanding access.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic [31:0] ALU_co_pype;
    logic [31:0] read_data2_pype2;
    logic [4:0]  WReg_pype2;
    logic [2:0]  writeback_control_pype2;
    logic [1:0]  MemRW_pype2;
    logic [1:0]  dsize_pype2;
    logic [2:0]  funct3_pype2;
    logic [31:0] PCp4_pype2;
    logic        is_csr_pype2;
    logic [11:0] csr_pype2;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic        misaligned_exc;
    logic [31:0] ALU_co_pype3;
    logic [31:0] load_data_pype3;
    logic [31:0] PCp4_pype3;
    logic [4:0]  WReg_pype3;
    logic [2:0]  writeback_control_pype3;
    logic        is_csr_pype3;
    logic [11:0] csr_pype3;
    logic [31:0] fwd_mem_data;

    int total = 0;
    int bad   = 0;

    mem_access_stage dut (
        .clk                     (clk),
        .rst                     (rst),
        .ALU_co_pype             (ALU_co_pype),
        .read_data2_pype2        (read_data2_pype2),
        .WReg_pype2              (WReg_pype2),
        .writeback_control_pype2 (writeback_control_pype2),
        .MemRW_pype2             (MemRW_pype2),
        .dsize_pype2             (dsize_pype2),
        .funct3_pype2            (funct3_pype2),
        .PCp4_pype2              (PCp4_pype2),
        .is_csr_pype2            (is_csr_pype2),
        .csr_pype2               (csr_pype2),
        .dmem_req                (dmem_req),
        .dmem_we                 (dmem_we),
        .dmem_addr               (dmem_addr),
        .dmem_be                 (dmem_be),
        .dmem_wdata              (dmem_wdata),
        .dmem_rdata              (dmem_rdata),
        .dmem_ack                (dmem_ack),
        .mem_stall               (mem_stall),
        .misaligned_exc          (misaligned_exc),
        .ALU_co_pype3            (ALU_co_pype3),
        .load_data_pype3         (load_data_pype3),
        .PCp4_pype3              (PCp4_pype3),
        .WReg_pype3              (WReg_pype3),
        .writeback_control_pype3 (writeback_control_pype3),
        .is_csr_pype3            (is_csr_pype3),
        .csr_pype3               (csr_pype3),
        .fwd_mem_data            (fwd_mem_data)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wreg;
        logic [2:0]  wbctl;
        logic [1:0]  memrw;
        logic [1:0]  dsize;
        logic [2:0]  f3;
        logic [31:0] rdata;
        logic        ack;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] fwd;
        logic        exc;
        logic [4:0]  wreg3;
        logic [2:0]  wbctl3;
        logic [31:0] load3;
    } vec_t;

    vec_t vecs[13];

    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wd,
                                 input logic [4:0] wreg, input logic [2:0] wbctl,
                                 input logic [1:0] memrw, input logic [1:0] dsize,
                                 input logic [2:0] f3, input logic [31:0] rdata,
                                 input logic ack);
        ALU_co_pype             = alu;
        read_data2_pype2        = wd;
        WReg_pype2              = wreg;
        writeback_control_pype2 = wbctl;
        MemRW_pype2             = memrw;
        dsize_pype2             = dsize;
        funct3_pype2            = f3;
        PCp4_pype2              = alu + 32'h1000;
        is_csr_pype2            = 1'b0;
        csr_pype2               = 12'h000;
        dmem_rdata              = rdata;
        dmem_ack                = ack;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait-state load: LH/LHU at 0x202 with three cycles of ack=0
    task automatic runSlowHalf(input logic [2:0] f3, input logic [31:0] exp, input string tag);
        @(negedge clk);
        applyStimulus(32'h202, 32'h0, 5'd9, 3'd1, 2'b10, 2'b01, f3, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput($sformatf("%s.stall%0d", tag, i), {31'b0, mem_stall}, 32'd1);
            checkOutput($sformatf("%s.req%0d", tag, i), {31'b0, dmem_req}, 32'd1);
            checkOutput($sformatf("%s.addr%0d", tag, i), dmem_addr, 32'h200);
            checkOutput($sformatf("%s.be%0d", tag, i), {28'b0, dmem_be}, 32'hC);
            @(posedge clk);
            #1;
            checkOutput($sformatf("%s.bubble%0d", tag, i), {29'b0, writeback_control_pype3}, 32'd0);
            checkOutput($sformatf("%s.bubreg%0d", tag, i), {27'b0, WReg_pype3}, 32'd0);
            @(negedge clk);
        end
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h8001_7FFF;
        #1;
        checkOutput({tag, ".stall_ack"}, {31'b0, mem_stall}, 32'd0);
        checkOutput({tag, ".fwd"}, fwd_mem_data, exp);
        @(posedge clk);
        #1;
        checkOutput({tag, ".load3"}, load_data_pype3, exp);
        checkOutput({tag, ".wreg3"}, {27'b0, WReg_pype3}, 32'd9);
        checkOutput({tag, ".wbctl3"}, {29'b0, writeback_control_pype3}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // name, alu, wd, wreg, wbctl, memrw, dsize, f3, rdata, ack,
        // req, addr, be, wdata, stall, fwd, exc, wreg3, wbctl3, load3
        vecs[0]  = '{"alu",     32'h1234, 32'h0, 5'd5, 3'd1, 2'b00, 2'b10, 3'b000, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h1234, 1'b0, 5'd5, 3'd1, 32'h0};
        vecs[1]  = '{"sb",      32'h103, 32'hAB, 5'd0, 3'd0, 2'b01, 2'b00, 3'b000, 32'h0, 1'b1,
                     1'b1, 32'h100, 4'b1000, 32'hABABABAB, 1'b0, 32'h103, 1'b0, 5'd0, 3'd0, 32'h0};
        vecs[2]  = '{"sh",      32'h102, 32'hBEEF, 5'd0, 3'd0, 2'b01, 2'b01, 3'b001, 32'h0, 1'b1,
                     1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b0, 32'h102, 1'b0, 5'd0, 3'd0, 32'h0};
        vecs[3]  = '{"sw",      32'h204, 32'h12345678, 5'd0, 3'd0, 2'b01, 2'b10, 3'b010, 32'h0, 1'b1,
                     1'b1, 32'h204, 4'b1111, 32'h12345678, 1'b0, 32'h204, 1'b0, 5'd0, 3'd0, 32'h0};
        vecs[4]  = '{"lb",      32'h101, 32'h0, 5'd7, 3'd1, 2'b10, 2'b00, 3'b000, 32'h11223344, 1'b1,
                     1'b1, 32'h100, 4'b0010, 32'h0, 1'b0, 32'h33, 1'b0, 5'd7, 3'd1, 32'h33};
        vecs[5]  = '{"lb_neg",  32'h103, 32'h0, 5'd7, 3'd1, 2'b10, 2'b00, 3'b000, 32'h80112233, 1'b1,
                     1'b1, 32'h100, 4'b1000, 32'h0, 1'b0, 32'hFFFFFF80, 1'b0, 5'd7, 3'd1, 32'hFFFFFF80};
        vecs[6]  = '{"lbu",     32'h103, 32'h0, 5'd7, 3'd1, 2'b10, 2'b00, 3'b100, 32'h80112233, 1'b1,
                     1'b1, 32'h100, 4'b1000, 32'h0, 1'b0, 32'h80, 1'b0, 5'd7, 3'd1, 32'h80};
        vecs[7]  = '{"lh",      32'h200, 32'h0, 5'd8, 3'd1, 2'b10, 2'b01, 3'b001, 32'h0000F00F, 1'b1,
                     1'b1, 32'h200, 4'b0011, 32'h0, 1'b0, 32'hFFFFF00F, 1'b0, 5'd8, 3'd1, 32'hFFFFF00F};
        vecs[8]  = '{"lw",      32'h10, 32'h0, 5'd10, 3'd1, 2'b10, 2'b10, 3'b010, 32'hCAFEF00D, 1'b1,
                     1'b1, 32'h10, 4'b1111, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 5'd10, 3'd1, 32'hCAFEF00D};
        vecs[9]  = '{"sh_mis",  32'h101, 32'h1, 5'd0, 3'd1, 2'b01, 2'b01, 3'b001, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h101, 1'b1, 5'd0, 3'd0, 32'h0};
        vecs[10] = '{"lw_mis",  32'h301, 32'h0, 5'd4, 3'd1, 2'b10, 2'b10, 3'b010, 32'h55, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h301, 1'b1, 5'd0, 3'd0, 32'h0};
        vecs[11] = '{"lh_mis",  32'h203, 32'h0, 5'd6, 3'd1, 2'b10, 2'b01, 3'b001, 32'h0, 1'b0,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h203, 1'b1, 5'd0, 3'd0, 32'h0};
        vecs[12] = '{"ack_idle", 32'h77, 32'h0, 5'd2, 3'd1, 2'b00, 2'b10, 3'b000, 32'hFFFFFFFF, 1'b1,
                     1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h77, 1'b0, 5'd2, 3'd1, 32'h0};

        // Reset with an access presented: no request, no stall, registers cleared
        rst = 1'b1;
        applyStimulus(32'h999, 32'h0, 5'd3, 3'd1, 2'b10, 2'b10, 3'b010, 32'h0, 1'b0);
        #1;
        checkOutput("rst.req", {31'b0, dmem_req}, 32'd0);
        checkOutput("rst.stall", {31'b0, mem_stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst.alu3", ALU_co_pype3, 32'h0);
        checkOutput("rst.wbctl3", {29'b0, writeback_control_pype3}, 32'd0);
        checkOutput("rst.load3", load_data_pype3, 32'h0);
        checkOutput("rst.exc", {31'b0, misaligned_exc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle vectors: zero-wait memory, non-memory ops and misaligned accesses
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].alu, vecs[i].wd, vecs[i].wreg, vecs[i].wbctl, vecs[i].memrw,
                          vecs[i].dsize, vecs[i].f3, vecs[i].rdata, vecs[i].ack);
            #1;
            checkOutput({vecs[i].name, ".req"}, {31'b0, dmem_req}, {31'b0, vecs[i].req});
            checkOutput({vecs[i].name, ".stall"}, {31'b0, mem_stall}, {31'b0, vecs[i].stall});
            checkOutput({vecs[i].name, ".fwd"}, fwd_mem_data, vecs[i].fwd);
            if (vecs[i].req) begin
                checkOutput({vecs[i].name, ".we"}, {31'b0, dmem_we}, {31'b0, vecs[i].memrw[0]});
                checkOutput({vecs[i].name, ".addr"}, dmem_addr, vecs[i].addr);
                checkOutput({vecs[i].name, ".be"}, {28'b0, dmem_be}, {28'b0, vecs[i].be});
                checkOutput({vecs[i].name, ".wdata"}, dmem_wdata, vecs[i].wdata);
            end
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, ".exc"}, {31'b0, misaligned_exc}, {31'b0, vecs[i].exc});
            checkOutput({vecs[i].name, ".wreg3"}, {27'b0, WReg_pype3}, {27'b0, vecs[i].wreg3});
            checkOutput({vecs[i].name, ".wbctl3"}, {29'b0, writeback_control_pype3}, {29'b0, vecs[i].wbctl3});
            checkOutput({vecs[i].name, ".load3"}, load_data_pype3, vecs[i].load3);
            checkOutput({vecs[i].name, ".alu3"}, ALU_co_pype3, vecs[i].alu);
        end

        // Three-wait-state half loads, signed then unsigned
        runSlowHalf(3'b001, 32'hFFFF8001, "lh_slow");
        runSlowHalf(3'b101, 32'h00008001, "lhu_slow");

        // Reset while an LB waits, then a late ack, then a clean LW
        @(negedge clk);
        applyStimulus(32'h5, 32'h0, 5'd8, 3'd1, 2'b10, 2'b00, 3'b000, 32'h0, 1'b0);
        #1;
        checkOutput("rstw.req_pre", {31'b0, dmem_req}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("rstw.bubble", {29'b0, writeback_control_pype3}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rstw.req_rst", {31'b0, dmem_req}, 32'd0);
        checkOutput("rstw.stall_rst", {31'b0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("rstw.alu3", ALU_co_pype3, 32'h0);
        checkOutput("rstw.wreg3", {27'b0, WReg_pype3}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(32'h40, 32'h0, 5'd2, 3'd1, 2'b00, 2'b10, 3'b000, 32'hFFFFFFFF, 1'b1);
        #1;
        checkOutput("late.req", {31'b0, dmem_req}, 32'd0);
        checkOutput("late.stall", {31'b0, mem_stall}, 32'd0);
        checkOutput("late.fwd", fwd_mem_data, 32'h40);
        @(posedge clk);
        #1;
        checkOutput("late.load3", load_data_pype3, 32'h0);
        checkOutput("late.wreg3", {27'b0, WReg_pype3}, 32'd2);
        @(negedge clk);
        applyStimulus(32'h0, 32'h0, 5'd3, 3'd1, 2'b10, 2'b10, 3'b010, 32'hDEADBEEF, 1'b1);
        #1;
        checkOutput("lw0.req", {31'b0, dmem_req}, 32'd1);
        checkOutput("lw0.addr", dmem_addr, 32'h0);
        checkOutput("lw0.stall", {31'b0, mem_stall}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lw0.load3", load_data_pype3, 32'hDEADBEEF);
        checkOutput("lw0.wreg3", {27'b0, WReg_pype3}, 32'd3);
        checkOutput("lw0.wbctl3", {29'b0, writeback_control_pype3}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
